// File: rtl/life_controller.sv
// Generation sequencer for the 8x8 Game of Life datapath.
// Holds the grid, paces generations and halts on extinction, still life or limit.
module life_controller #(
  parameter int TICK_DIV = 4,
  parameter int GEN_W    = 16,
  parameter int MAX_GEN  = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [63:0]      seed,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [63:0]      grid_evolve,
  output logic [63:0]      grid,
  output logic [GEN_W-1:0] generation,
  output logic             running,
  output logic             gen_tick,
  output logic             done,
  output logic             stable,
  output logic             extinct
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] divider, divider_n;
  logic             eval;
  logic             commit;
  logic             set_stable;
  logic             set_extinct;
  logic             at_limit;

  assign at_limit = (MAX_GEN != 0) && (generation == GEN_W'(MAX_GEN));

  always_comb begin
    state_n   = state;
    divider_n = divider;
    eval      = 1'b0;
    if (load) begin
      state_n   = IDLE;
      divider_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (stop) begin
            state_n = IDLE;
          end else if (start) begin
            state_n   = RUN;
            divider_n = '0;
          end else if (step) begin
            eval = 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_n   = IDLE;
            divider_n = '0;
          end else if (divider == DIV_W'(TICK_DIV - 1)) begin
            eval      = 1'b1;
            divider_n = '0;
          end else begin
            divider_n = divider + 1'b1;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  // Halt checks are ordered: empty grid wins over still life over limit.
  always_comb begin
    commit      = 1'b0;
    set_stable  = 1'b0;
    set_extinct = 1'b0;
    if (eval) begin
      if (grid == '0) begin
        set_extinct = 1'b1;
      end else if (grid_evolve == grid) begin
        set_stable = 1'b1;
      end else if (!at_limit) begin
        commit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      divider    <= '0;
      grid       <= '0;
      generation <= '0;
      gen_tick   <= 1'b0;
      stable     <= 1'b0;
      extinct    <= 1'b0;
    end else begin
      state    <= (eval && !commit) ? DONE : state_n;
      divider  <= divider_n;
      gen_tick <= commit;
      if (load) begin
        grid       <= seed;
        generation <= '0;
        stable     <= 1'b0;
        extinct    <= 1'b0;
      end else begin
        if (commit) begin
          grid       <= grid_evolve;
          generation <= generation + 1'b1;
        end
        if (set_stable) stable <= 1'b1;
        if (set_extinct) extinct <= 1'b1;
      end
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule
